snes_controller_emulator: RTL and testbench

Device-side responder for the SNES/NES serial controller protocol: the host drives Strobe_Latch and Shift_Clock, and this block returns button state on Data. It lets a board stand in for a physical pad, so a second board's player logic and its SNES input path can be driven and tested without hardware. It sits at the pad connector, with Buttons supplied by local switches or a test harness.

---
 rtl/snes_controller_emulator_if.sv | 9 +
 rtl/snes_controller_emulator.sv | 112 +++++++++++
 tb/tb_snes_controller_emulator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/snes_controller_emulator_if.sv
// Pad-connector signals between an SNES/NES host and the emulated controller.
interface snes_controller_emulator_if;
  logic Strobe_Latch;
  logic Shift_Clock;
  logic Data;

  modport master (output Strobe_Latch, output Shift_Clock, input Data);
  modport slave  (input Strobe_Latch, input Shift_Clock, output Data);
endinterface

// File: rtl/snes_controller_emulator.sv
// Device-side SNES/NES pad responder: synchronizes host latch/shift strobes and
// serializes the button image (active-low, LSB first) onto Data.
module snes_controller_emulator #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             Clock,
  input  logic                             Reset,
  snes_controller_emulator_if.slave        pad,
  input  logic                             Mode,
  input  logic [11:0]                      Buttons,
  output logic                             Polled,
  output logic [4:0]                       BitIndex
);

  typedef enum logic [1:0] {ST_IDLE, ST_LATCHED, ST_SHIFTING, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latch_sync, shift_sync;
  logic                   latch_hist, shift_hist;
  logic                   latch_rise, latch_fall, shift_rise;
  logic [15:0]            sr_q, sr_d;
  logic [4:0]             idx_q, idx_d;
  logic                   polled_q, polled_d;
  logic                   mode_q, mode_d;
  logic [4:0]             frame_len;

  function automatic logic [15:0] frame_image(input logic nes, input logic [11:0] b);
    logic [15:0] img;
    if (nes)
      img = {8'h00, ~{b[7], b[6], b[5], b[4], b[3], b[2], b[0], b[8]}};
    else
      img = {4'hF, ~b};
    return img;
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      latch_sync <= '0;
      shift_sync <= '0;
      latch_hist <= 1'b0;
      shift_hist <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad.Strobe_Latch};
      shift_sync <= {shift_sync[SYNC_STAGES-2:0], pad.Shift_Clock};
      latch_hist <= latch_sync[SYNC_STAGES-1];
      shift_hist <= shift_sync[SYNC_STAGES-1];
    end
  end

  assign latch_rise = latch_sync[SYNC_STAGES-1] & ~latch_hist;
  assign latch_fall = ~latch_sync[SYNC_STAGES-1] & latch_hist;
  assign shift_rise = shift_sync[SYNC_STAGES-1] & ~shift_hist;
  assign frame_len  = mode_q ? 5'd8 : 5'd16;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      sr_q     <= '1;
      idx_q    <= '0;
      polled_q <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      polled_q <= polled_d;
      mode_q   <= mode_d;
    end
  end

  // A latch rise pre-empts everything, so a coincident shift edge is dropped.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    polled_d = 1'b0;
    mode_d   = mode_q;
    if (latch_rise) begin
      state_d = ST_LATCHED;
      sr_d    = frame_image(Mode, Buttons);
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_LATCHED: begin
          sr_d  = frame_image(Mode, Buttons);
          idx_d = '0;
          if (latch_fall) begin
            state_d = ST_SHIFTING;
            mode_d  = Mode;
          end
        end
        ST_SHIFTING: begin
          if (shift_rise) begin
            sr_d  = {1'b0, sr_q[15:1]};
            idx_d = idx_q + 5'd1;
            if (idx_d == frame_len) begin
              polled_d = 1'b1;
              state_d  = ST_DONE;
              if (mode_q) sr_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pad.Data = sr_q[0];
  assign Polled   = polled_q;
  assign BitIndex = idx_q;

endmodule

// File: tb/tb_snes_controller_emulator.sv
// Directed bench for snes_controller_emulator: table-driven frames plus reset,
// abort, button-change and synchronizer-latency sequences.
module tb_snes_controller_emulator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Mode = 1'b0;
  logic [11:0] Buttons = '0;
  logic        Polled, Polled3;
  logic [4:0]  BitIndex, BitIndex3;
  int          tests = 0;
  int          failed = 0;
  int          polled_cnt = 0;

  snes_controller_emulator_if pad ();
  snes_controller_emulator_if pad3 ();

  snes_controller_emulator #(.SYNC_STAGES(2)) dut (
    .Clock(Clock), .Reset(Reset), .pad(pad), .Mode(Mode), .Buttons(Buttons),
    .Polled(Polled), .BitIndex(BitIndex));

  snes_controller_emulator #(.SYNC_STAGES(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .pad(pad3), .Mode(Mode), .Buttons(Buttons),
    .Polled(Polled3), .BitIndex(BitIndex3));

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (Polled === 1'b1) polled_cnt++;

  typedef struct {
    logic        mode;
    logic [11:0] buttons;
    logic [15:0] frame;
    int          len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic latch_pulse();
    pad.Strobe_Latch = 1'b1;
    wait_n(6);
    pad.Strobe_Latch = 1'b0;
    wait_n(6);
  endtask

  task automatic shift_edge();
    pad.Shift_Clock = 1'b0;
    wait_n(6);
    pad.Shift_Clock = 1'b1;
    wait_n(6);
  endtask

  // Reads a frame already in SHIFTING, then confirms DONE behaviour.
  task automatic read_frame(input string name, input logic [15:0] frame, input int len);
    int base;
    base = polled_cnt;
    check({name, " idx0"}, 32'(BitIndex), 0);
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s bit%0d", name, k), 32'(pad.Data), 32'(frame[k]));
      shift_edge();
    end
    check({name, " data_done"}, 32'(pad.Data), 0);
    check({name, " idx_done"}, 32'(BitIndex), 32'(len));
    check({name, " polled"}, 32'(polled_cnt - base), 1);
    shift_edge();
    check({name, " data_extra"}, 32'(pad.Data), 0);
    check({name, " idx_sat"}, 32'(BitIndex), 32'(len));
    check({name, " polled_once"}, 32'(polled_cnt - base), 1);
  endtask

  initial begin
    int base;
    vecs[0] = '{mode: 1'b0, buttons: 12'h001, frame: 16'hFFFE, len: 16};
    vecs[1] = '{mode: 1'b1, buttons: 12'h110, frame: 16'h00EE, len: 8};
    vecs[2] = '{mode: 1'b0, buttons: 12'hFFF, frame: 16'hF000, len: 16};
    vecs[3] = '{mode: 1'b0, buttons: 12'h000, frame: 16'hFFFF, len: 16};
    vecs[4] = '{mode: 1'b1, buttons: 12'h0FF, frame: 16'h0001, len: 8};
    vecs[5] = '{mode: 1'b0, buttons: 12'hA5C, frame: 16'hF5A3, len: 16};

    pad.Strobe_Latch  = 1'b0;
    pad.Shift_Clock   = 1'b1;
    pad3.Strobe_Latch = 1'b0;
    pad3.Shift_Clock  = 1'b1;
    wait_n(3);
    check("rst data", 32'(pad.Data), 1);
    check("rst idx", 32'(BitIndex), 0);
    check("rst polled", 32'(Polled), 0);
    Reset = 1'b0;
    wait_n(8);
    check("phantom idx", 32'(BitIndex), 0);
    check("phantom data", 32'(pad.Data), 1);

    for (int v = 0; v < 6; v++) begin
      Mode    = vecs[v].mode;
      Buttons = vecs[v].buttons;
      latch_pulse();
      read_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].len);
    end

    // Reset in the middle of a frame
    Mode = 1'b0; Buttons = 12'h001;
    latch_pulse();
    repeat (5) shift_edge();
    check("mid idx5", 32'(BitIndex), 5);
    Reset = 1'b1;
    #1;
    check("mid rst data", 32'(pad.Data), 1);
    check("mid rst idx", 32'(BitIndex), 0);
    wait_n(2);
    Reset = 1'b0;
    repeat (3) shift_edge();
    check("post rst idx", 32'(BitIndex), 0);
    check("post rst data", 32'(pad.Data), 1);

    // Buttons change mid-frame does not disturb it
    Buttons = 12'h000;
    latch_pulse();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("chg bit%0d", k), 32'(pad.Data), 1);
      shift_edge();
    end
    Buttons = 12'hFFF;
    for (int k = 3; k < 16; k++) begin
      check($sformatf("chg bit%0d", k), 32'(pad.Data), 1);
      shift_edge();
    end
    check("chg done", 32'(pad.Data), 0);
    latch_pulse();
    check("chg next bit0", 32'(pad.Data), 0);
    shift_edge();
    check("chg next bit1", 32'(pad.Data), 0);

    // Latch rise coincident with a shift rise aborts the frame
    Buttons = 12'h002;
    latch_pulse();
    repeat (6) shift_edge();
    base = polled_cnt;
    pad.Shift_Clock = 1'b0;
    wait_n(6);
    pad.Shift_Clock  = 1'b1;
    pad.Strobe_Latch = 1'b1;
    wait_n(6);
    check("abort idx", 32'(BitIndex), 0);
    check("abort live bit0", 32'(pad.Data), 1);
    Buttons = 12'h003;
    wait_n(4);
    check("abort track", 32'(pad.Data), 0);
    Buttons = 12'h002;
    wait_n(4);
    check("abort no polled", 32'(polled_cnt - base), 0);
    pad.Strobe_Latch = 1'b0;
    wait_n(6);
    read_frame("abort frame", 16'hFFFD, 16);

    // Synchronizer latency with SYNC_STAGES = 3
    Mode = 1'b0; Buttons = 12'h001;
    pad3.Strobe_Latch = 1'b1;
    wait_n(6);
    pad3.Strobe_Latch = 1'b0;
    wait_n(6);
    check("lat3 bit0", 32'(pad3.Data), 0);
    pad3.Shift_Clock = 1'b0;
    wait_n(6);
    pad3.Shift_Clock = 1'b1;
    wait_n(3);
    check("lat3 idx@3", 32'(BitIndex3), 0);
    check("lat3 data@3", 32'(pad3.Data), 0);
    wait_n(1);
    check("lat3 idx@4", 32'(BitIndex3), 1);
    check("lat3 data@4", 32'(pad3.Data), 1);
    wait_n(6);
    pad3.Shift_Clock = 1'b0;
    wait_n(6);
    pad3.Shift_Clock = 1'b1;
    wait_n(2);
    pad3.Shift_Clock = 1'b0;
    wait_n(8);
    tests++;
    if (!(BitIndex3 == 5'd1 || BitIndex3 == 5'd2)) begin
      failed++;
      $display("FAIL lat3 glitch: got %0d expected 1 or 2", BitIndex3);
    end
    pad3.Shift_Clock = 1'b1;
    wait_n(8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
